// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// States, datapath select encodings and decoded-op bit positions.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_ADC   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_SBB   = 3'd3;
  localparam logic [2:0] ALU_PASSB = 3'd4;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_IMM = 2'd2;
  localparam logic [1:0] PC_REG = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_IMM  = 2'd2;
  localparam logic [1:0] WB_LINK = 2'd3;

  localparam int N_OPS   = 25;
  localparam int OP_BCC  = 0;
  localparam int OP_BCS  = 1;
  localparam int OP_BNE  = 2;
  localparam int OP_BEQ  = 3;
  localparam int OP_BAL  = 4;
  localparam int OP_ADD  = 5;
  localparam int OP_ADC  = 6;
  localparam int OP_SUB  = 7;
  localparam int OP_SBB  = 8;
  localparam int OP_SUBI = 9;
  localparam int OP_MOV  = 10;
  localparam int OP_STRI = 11;
  localparam int OP_STR  = 12;
  localparam int OP_CMP  = 13;
  localparam int OP_ADDI = 14;
  localparam int OP_LDR  = 15;
  localparam int OP_LDRI = 16;
  localparam int OP_LLI  = 17;
  localparam int OP_LHI  = 18;
  localparam int OP_JMP  = 19;
  localparam int OP_JALI = 20;
  localparam int OP_JAL  = 21;
  localparam int OP_JR   = 22;
  localparam int OP_OUTR = 23;
  localparam int OP_HLT  = 24;

  function automatic logic is_load(
    input logic [N_OPS-1:0] op
  );
    return op[OP_LDR] | op[OP_LDRI];
  endfunction

  function automatic logic is_store(
    input logic [N_OPS-1:0] op
  );
    return op[OP_STR] | op[OP_STRI];
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_branch_cond.sv
// Branch condition evaluation from latched branch strobes and ALU flags.
// Strobe order: BCC, BCS, BNE, BEQ, BAL.
module branch_cond (
  input  logic [4:0] br,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       taken
);

  assign taken = (br[0] & ~flag_c)
               | (br[1] &  flag_c)
               | (br[2] & ~flag_z)
               | (br[3] &  flag_z)
               |  br[4];

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM with memory handshake and timeout watchdog.
// Define CTRL_ILLEGAL_TRAP_EN to fault on zero/multi-hot decoded ops.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       dec_BCC,
  input  logic       dec_BCS,
  input  logic       dec_BNE,
  input  logic       dec_BEQ,
  input  logic       dec_BAL,
  input  logic       dec_ADD,
  input  logic       dec_ADC,
  input  logic       dec_SUB,
  input  logic       dec_SBB,
  input  logic       dec_SUBI,
  input  logic       dec_MOV,
  input  logic       dec_STRI,
  input  logic       dec_STR,
  input  logic       dec_CMP,
  input  logic       dec_ADDI,
  input  logic       dec_LDR,
  input  logic       dec_LDRI,
  input  logic       dec_LLI,
  input  logic       dec_LHI,
  input  logic       dec_JMP,
  input  logic       dec_JALI,
  input  logic       dec_JAL,
  input  logic       dec_JR,
  input  logic       dec_OUTR,
  input  logic       dec_HLT,
  input  logic       flag_c,
  input  logic       flag_z,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       rf_we,
  output logic [1:0] rf_wsel,
  output logic       imm_hi,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic       flags_we,
  output logic       out_we,
  output logic       halted,
  output logic       fault
);

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t             state_q;
  state_t             state_d;
  logic [N_OPS-1:0]   dec;
  logic [N_OPS-1:0]   op_q;
  logic [7:0]         wait_q;
  logic [7:0]         wait_d;
  logic               fault_q;
  logic               fault_d;
  logic               req;
  logic               timeout;
  logic               taken;
  logic               legal;
  logic               alu_st;
  logic [2:0]         alu_code;
  logic               alu_imm;

  assign dec = {
    dec_HLT, dec_OUTR, dec_JR, dec_JAL, dec_JALI,
    dec_JMP, dec_LHI, dec_LLI, dec_LDRI, dec_LDR,
    dec_ADDI, dec_CMP, dec_STR, dec_STRI, dec_MOV,
    dec_SUBI, dec_SBB, dec_SUB, dec_ADC, dec_ADD,
    dec_BAL, dec_BEQ, dec_BNE, dec_BCS, dec_BCC
  };

  branch_cond u_branch_cond (
    .br     (op_q[OP_BAL:OP_BCC]),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .taken  (taken)
  );

  // A fetch stays requested once started, even if run drops.
  assign req = rst_n
             & (((state_q == S_FETCH) & (run | (wait_q != 8'd0)))
             |  (state_q == S_MEM));

  assign timeout = req & ~mem_ack & ((wait_q + 8'd1) == WAIT_MAX);
  assign wait_d  = (req & ~mem_ack) ? wait_q + 8'd1 : 8'd0;
  assign legal   = $onehot(op_q);

  assign alu_st = (state_q == S_EXEC)
                | (state_q == S_MEM)
                | (state_q == S_WB);

  assign alu_code =
    op_q[OP_MOV] ? ALU_PASSB :
    op_q[OP_SBB] ? ALU_SBB :
    (op_q[OP_SUB] | op_q[OP_SUBI] | op_q[OP_CMP]) ? ALU_SUB :
    op_q[OP_ADC] ? ALU_ADC : ALU_ADD;

  assign alu_imm = op_q[OP_SUBI] | op_q[OP_ADDI]
                 | op_q[OP_LDRI] | op_q[OP_STRI];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_q | fault_d;
      if (state_q == S_DECODE) op_q <= dec;
    end
  end

  always_comb begin
    state_d      = state_q;
    fault_d      = 1'b0;
    mem_req      = req;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_INC;
    rf_we        = 1'b0;
    rf_wsel      = WB_ALU;
    imm_hi       = 1'b0;
    alu_op       = alu_st ? alu_code : ALU_ADD;
    alu_src      = alu_st & alu_imm;
    flags_we     = 1'b0;
    out_we       = 1'b0;
    halted       = 1'b0;
    fault        = fault_q;
    case (state_q)
      S_FETCH: begin
        if (req & mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        if (!legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          fault_d = 1'b1;
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end else begin
          unique case (1'b1)
            (op_q[OP_ADD] | op_q[OP_ADC] | op_q[OP_SUB]
             | op_q[OP_SBB] | op_q[OP_SUBI] | op_q[OP_ADDI]): begin
              flags_we = 1'b1;
              state_d  = S_WB;
            end
            op_q[OP_MOV]: state_d = S_WB;
            op_q[OP_CMP]: flags_we = 1'b1;
            (|op_q[OP_BAL:OP_BCC]): begin
              pc_we  = taken;
              pc_src = taken ? PC_BR : PC_INC;
            end
            op_q[OP_JMP]: begin
              pc_we  = 1'b1;
              pc_src = PC_IMM;
            end
            op_q[OP_JR]: begin
              pc_we  = 1'b1;
              pc_src = PC_REG;
            end
            (op_q[OP_JAL] | op_q[OP_JALI]): begin
              pc_we   = 1'b1;
              pc_src  = op_q[OP_JAL] ? PC_REG : PC_IMM;
              rf_we   = 1'b1;
              rf_wsel = WB_LINK;
            end
            (is_load(op_q) | is_store(op_q)): state_d = S_MEM;
            (op_q[OP_LLI] | op_q[OP_LHI]): state_d = S_WB;
            op_q[OP_OUTR]: out_we = 1'b1;
            op_q[OP_HLT]: state_d = S_HALT;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        mem_addr_sel = req;
        mem_we       = req & is_store(op_q);
        if (req & mem_ack) begin
          state_d = is_load(op_q) ? S_WB : S_FETCH;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wsel = is_load(op_q) ? WB_MEM
                : (op_q[OP_LLI] | op_q[OP_LHI]) ? WB_IMM
                : WB_ALU;
        imm_hi  = op_q[OP_LHI];
        state_d = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm.
// One task per scenario, hand-computed expectations.
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [24:0] dec;
  logic        flag_c, flag_z, mem_ack;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0]  pc_src, rf_wsel;
  logic        rf_we, imm_hi, alu_src, flags_we, out_we;
  logic        halted, fault;
  logic [2:0]  alu_op;
  logic [18:0] outs;

  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we,
                 pc_src, rf_we, rf_wsel, imm_hi, alu_op,
                 alu_src, flags_we, out_we, halted, fault};

  cpu_ctrl_fsm #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .dec_BCC(dec[0]), .dec_BCS(dec[1]), .dec_BNE(dec[2]),
    .dec_BEQ(dec[3]), .dec_BAL(dec[4]), .dec_ADD(dec[5]),
    .dec_ADC(dec[6]), .dec_SUB(dec[7]), .dec_SBB(dec[8]),
    .dec_SUBI(dec[9]), .dec_MOV(dec[10]), .dec_STRI(dec[11]),
    .dec_STR(dec[12]), .dec_CMP(dec[13]), .dec_ADDI(dec[14]),
    .dec_LDR(dec[15]), .dec_LDRI(dec[16]), .dec_LLI(dec[17]),
    .dec_LHI(dec[18]), .dec_JMP(dec[19]), .dec_JALI(dec[20]),
    .dec_JAL(dec[21]), .dec_JR(dec[22]), .dec_OUTR(dec[23]),
    .dec_HLT(dec[24]),
    .flag_c(flag_c), .flag_z(flag_z), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .imm_hi(imm_hi), .alu_op(alu_op), .alu_src(alu_src),
    .flags_we(flags_we), .out_we(out_we),
    .halted(halted), .fault(fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    mem_ack = 1'b0;
    dec = '0;
    flag_c = 1'b0;
    flag_z = 1'b0;
    #7;
    rst_n = 1'b1;
    tick();
  endtask

  // Zero-wait fetch; returns positioned in DECODE.
  task automatic fetch_op(input int idx);
    dec = (idx < 0) ? 25'd0 : (25'd1 << idx);
    run = 1'b1;
    mem_ack = 1'b1;
    tick();
    run = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b1;
    mem_ack = 1'b1;
    dec = '1;
    flag_c = 1'b1;
    flag_z = 1'b1;
    #2;
    vec++;
    if (outs !== 19'd0) begin
      errs++;
      $display("FAIL reset_outs: got %h want 0", outs);
    end
    #10;
    vec++;
    if (outs !== 19'd0 || dut.state_q !== S_FETCH) begin
      errs++;
      $display("FAIL reset_hold: outs %h state %0d want 0/FETCH",
               outs, dut.state_q);
    end
    do_reset();
    #1;
    vec++;
    if (outs !== 19'd0 || dut.state_q !== S_FETCH) begin
      errs++;
      $display("FAIL reset_idle: outs %h state %0d want 0/FETCH",
               outs, dut.state_q);
    end
  endtask

  task automatic test_add();
    do_reset();
    dec = 25'd1 << OP_ADD;
    run = 1'b1;
    mem_ack = 1'b0;
    #1;
    vec++;
    if ({mem_req, ir_we, pc_we, mem_addr_sel} !== 4'b1000) begin
      errs++;
      $display("FAIL add_fetch_wait: got %b want 1000",
               {mem_req, ir_we, pc_we, mem_addr_sel});
    end
    tick();
    mem_ack = 1'b1;
    #1;
    vec++;
    if ({mem_req, ir_we, pc_we, pc_src, mem_addr_sel} !== 6'b111000) begin
      errs++;
      $display("FAIL add_fetch_ack: got %b want 111000",
               {mem_req, ir_we, pc_we, pc_src, mem_addr_sel});
    end
    tick();
    run = 1'b0;
    mem_ack = 1'b0;
    #1;
    vec++;
    if (dut.state_q !== S_DECODE || mem_req !== 1'b0) begin
      errs++;
      $display("FAIL add_decode: state %0d req %b want DECODE/0",
               dut.state_q, mem_req);
    end
    tick();
    vec++;
    if (dut.state_q !== S_EXEC
        || {flags_we, alu_op, alu_src, rf_we} !== 6'b100000) begin
      errs++;
      $display("FAIL add_exec: state %0d ctl %b want EXEC/100000",
               dut.state_q, {flags_we, alu_op, alu_src, rf_we});
    end
    tick();
    vec++;
    if (dut.state_q !== S_WB || {rf_we, rf_wsel} !== 3'b100) begin
      errs++;
      $display("FAIL add_wb: state %0d wb %b want WB/100",
               dut.state_q, {rf_we, rf_wsel});
    end
    tick();
    vec++;
    if (dut.state_q !== S_FETCH) begin
      errs++;
      $display("FAIL add_done: state %0d want FETCH", dut.state_q);
    end
  endtask

  task automatic test_beq(input logic z, input logic exp);
    do_reset();
    flag_z = z;
    fetch_op(OP_BEQ);
    tick();
    vec++;
    if (dut.state_q !== S_EXEC
        || {pc_we, pc_src} !== (exp ? 3'b101 : 3'b000)) begin
      errs++;
      $display("FAIL beq_z%0b: state %0d pc %b want EXEC/%b",
               z, dut.state_q, {pc_we, pc_src},
               exp ? 3'b101 : 3'b000);
    end
    tick();
    vec++;
    if (dut.state_q !== S_FETCH) begin
      errs++;
      $display("FAIL beq_len_z%0b: state %0d want FETCH",
               z, dut.state_q);
    end
  endtask

  task automatic test_load();
    do_reset();
    fetch_op(OP_LDR);
    tick();
    vec++;
    if ({alu_op, alu_src, mem_req} !== 5'b00000) begin
      errs++;
      $display("FAIL ldr_exec: got %b want 00000",
               {alu_op, alu_src, mem_req});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      #1;
      vec++;
      if (dut.state_q !== S_MEM
          || {mem_req, mem_addr_sel, mem_we} !== 3'b110) begin
        errs++;
        $display("FAIL ldr_mem%0d: state %0d req %b want MEM/110",
                 i, dut.state_q, {mem_req, mem_addr_sel, mem_we});
      end
      tick();
    end
    mem_ack = 1'b0;
    vec++;
    if (dut.state_q !== S_WB || {rf_we, rf_wsel} !== 3'b101) begin
      errs++;
      $display("FAIL ldr_wb: state %0d wb %b want WB/101",
               dut.state_q, {rf_we, rf_wsel});
    end
    tick();
    vec++;
    if (dut.state_q !== S_FETCH) begin
      errs++;
      $display("FAIL ldr_done: state %0d want FETCH", dut.state_q);
    end
  endtask

  task automatic test_store();
    do_reset();
    fetch_op(OP_STRI);
    tick();
    vec++;
    if ({alu_op, alu_src} !== 4'b0001) begin
      errs++;
      $display("FAIL stri_exec: got %b want 0001", {alu_op, alu_src});
    end
    tick();
    mem_ack = 1'b1;
    #1;
    vec++;
    if ({mem_req, mem_addr_sel, mem_we} !== 3'b111) begin
      errs++;
      $display("FAIL stri_mem: got %b want 111",
               {mem_req, mem_addr_sel, mem_we});
    end
    tick();
    mem_ack = 1'b0;
    vec++;
    if (dut.state_q !== S_FETCH || rf_we !== 1'b0) begin
      errs++;
      $display("FAIL stri_done: state %0d rf_we %b want FETCH/0",
               dut.state_q, rf_we);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    dec = 25'd1 << OP_ADD;
    run = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      #1;
      vec++;
      if (mem_req !== 1'b1 || fault !== 1'b0) begin
        errs++;
        $display("FAIL wdog_req%0d: req %b fault %b want 1/0",
                 i, mem_req, fault);
      end
      tick();
    end
    #1;
    vec++;
    if (dut.state_q !== S_HALT
        || {halted, fault, mem_req} !== 3'b110) begin
      errs++;
      $display("FAIL wdog_fault: state %0d hfr %b want HALT/110",
               dut.state_q, {halted, fault, mem_req});
    end
    do_reset();
    run = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      mem_ack = (i == 15);
      #1;
      vec++;
      if (mem_req !== 1'b1) begin
        errs++;
        $display("FAIL wdog2_req%0d: got %b want 1", i, mem_req);
      end
      tick();
    end
    mem_ack = 1'b0;
    run = 1'b0;
    #1;
    vec++;
    if (dut.state_q !== S_DECODE || {halted, fault} !== 2'b00) begin
      errs++;
      $display("FAIL wdog_ack_wins: state %0d hf %b want DECODE/00",
               dut.state_q, {halted, fault});
    end
  endtask

  task automatic test_halt();
    do_reset();
    fetch_op(OP_HLT);
    tick();
    tick();
    run = 1'b1;
    #1;
    vec++;
    if ({halted, fault, mem_req} !== 3'b100) begin
      errs++;
      $display("FAIL hlt_state: hfr %b want 100",
               {halted, fault, mem_req});
    end
    tick();
    tick();
    vec++;
    if ({halted, mem_req} !== 2'b10) begin
      errs++;
      $display("FAIL hlt_stays: hr %b want 10", {halted, mem_req});
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if (outs !== 19'd0 || dut.state_q !== S_FETCH) begin
      errs++;
      $display("FAIL hlt_reset: outs %h state %0d want 0/FETCH",
               outs, dut.state_q);
    end
    run = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_midreset();
    do_reset();
    run = 1'b1;
    #1;
    vec++;
    if (mem_req !== 1'b1) begin
      errs++;
      $display("FAIL midrst_req: got %b want 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if (mem_req !== 1'b0 || dut.state_q !== S_FETCH) begin
      errs++;
      $display("FAIL midrst_drop: req %b state %0d want 0/FETCH",
               mem_req, dut.state_q);
    end
    run = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_misc();
    do_reset();
    fetch_op(OP_JAL);
    tick();
    vec++;
    if ({pc_we, pc_src, rf_we, rf_wsel} !== 6'b111111) begin
      errs++;
      $display("FAIL jal_exec: got %b want 111111",
               {pc_we, pc_src, rf_we, rf_wsel});
    end
    tick();
    fetch_op(OP_MOV);
    tick();
    vec++;
    if ({alu_op, flags_we} !== 4'b1000) begin
      errs++;
      $display("FAIL mov_exec: got %b want 1000", {alu_op, flags_we});
    end
    tick();
    tick();
    fetch_op(OP_CMP);
    tick();
    vec++;
    if ({alu_op, flags_we} !== 4'b0101) begin
      errs++;
      $display("FAIL cmp_exec: got %b want 0101", {alu_op, flags_we});
    end
    tick();
    vec++;
    if (dut.state_q !== S_FETCH) begin
      errs++;
      $display("FAIL cmp_len: state %0d want FETCH", dut.state_q);
    end
    fetch_op(OP_LHI);
    tick();
    tick();
    vec++;
    if ({rf_we, rf_wsel, imm_hi} !== 4'b1101) begin
      errs++;
      $display("FAIL lhi_wb: got %b want 1101",
               {rf_we, rf_wsel, imm_hi});
    end
    tick();
    fetch_op(OP_OUTR);
    tick();
    vec++;
    if ({out_we, rf_we, pc_we} !== 3'b100) begin
      errs++;
      $display("FAIL outr_exec: got %b want 100", {out_we, rf_we, pc_we});
    end
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    fetch_op(-1);
    tick();
    vec++;
    if ({pc_we, rf_we, flags_we, out_we, mem_req} !== 5'b00000) begin
      errs++;
      $display("FAIL nop_exec: got %b want 00000",
               {pc_we, rf_we, flags_we, out_we, mem_req});
    end
    tick();
    vec++;
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (dut.state_q !== S_HALT || {halted, fault} !== 2'b11) begin
      errs++;
      $display("FAIL illegal_trap: state %0d hf %b want HALT/11",
               dut.state_q, {halted, fault});
    end
`else
    if (dut.state_q !== S_FETCH || fault !== 1'b0) begin
      errs++;
      $display("FAIL illegal_nop: state %0d fault %b want FETCH/0",
               dut.state_q, fault);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_beq(1'b1, 1'b1);
    test_beq(1'b0, 1'b0);
    test_load();
    test_store();
    test_timeout();
    test_halt();
    test_midreset();
    test_misc();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
